// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC fetch sequencer: state encoding and default timing/step values.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam int unsigned DEF_STEP     = 4;
    localparam int unsigned DEF_MAX_WAIT = 15;

endpackage

// File: rtl/fetch_timer.sv
// Purpose: counts consecutive unacknowledged fetch cycles and flags the one that exhausts the budget.
// Latency: expired is combinational on the cycle whose count would reach MAX_WAIT.
// Backpressure: none; clr dominates en.
module fetch_timer
    import pc_seq_pkg::*;
#(
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 8'd1;
        end
    end

    // This waiting cycle is the MAX_WAIT-th one without an ack.
    assign expired = en && (count == 8'(MAX_WAIT - 1));

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Purpose: holds the PC, fetches one word per PC over req/ack, hands words to decode over valid/ready.
// Latency: mem_req one cycle after start/ir_ready; ir_valid one cycle after mem_ack.
// Backpressure: ir_ready low holds ISSUE with ir stable and no new request; mem_req holds until mem_ack.
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      STEP     = DEF_STEP,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned      MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [31:0]      mem_data,
    output logic             ir_valid,
    output logic [31:0]      ir,
    output logic [WIDTH-1:0] ir_pc,
    input  logic             ir_ready,
    output logic [WIDTH-1:0] pc,
    output logic [1:0]       state,
    output logic             timeout
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [WIDTH-1:0] ir_pc_q, ir_pc_d;
    logic             ir_valid_q, ir_valid_d;
    logic             timeout_q, timeout_d;
    logic             halt_lat_q, halt_lat_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic             wait_expired;

    fetch_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     ((state_q != ST_FETCH) || mem_ack),
        .en      ((state_q == ST_FETCH) && !mem_ack),
        .expired (wait_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            timeout_q  <= 1'b0;
            halt_lat_q <= 1'b0;
            pend_q     <= 1'b0;
            pend_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            timeout_q  <= timeout_d;
            halt_lat_q <= halt_lat_d;
            pend_q     <= pend_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        timeout_d  = timeout_q;
        halt_lat_d = halt_lat_q | (halt && (state_q != ST_HALT));
        pend_d     = pend_q;
        pend_pc_d  = pend_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect_valid) pc_d = redirect_pc;
                if (halt || halt_lat_q)  state_d = ST_HALT;
                else if (start)          state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    // A redirect seen during this request makes the returned word stale.
                    if (pend_q || redirect_valid) begin
                        pc_d   = redirect_valid ? redirect_pc : pend_pc_q;
                        pend_d = 1'b0;
                    end else begin
                        ir_d       = mem_data;
                        ir_pc_d    = pc_q;
                        pc_d       = pc_q + STEP_W;
                        ir_valid_d = 1'b1;
                        state_d    = ST_ISSUE;
                    end
                end else begin
                    if (redirect_valid) begin
                        pend_d    = 1'b1;
                        pend_pc_d = redirect_pc;
                    end
                    if (wait_expired) begin
                        timeout_d = 1'b1;
                        state_d   = ST_HALT;
                    end
                end
            end
            ST_ISSUE: begin
                if (redirect_valid) pc_d = redirect_pc;
                if (ir_ready) begin
                    ir_valid_d = 1'b0;
                    state_d    = (halt || halt_lat_q) ? ST_HALT : ST_FETCH;
                end
            end
            default: ;
        endcase
    end

    assign mem_req  = (state_q == ST_FETCH);
    assign mem_addr = pc_q;
    assign pc       = pc_q;
    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;
    assign timeout  = timeout_q;
    assign state    = state_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed plus randomized bench for pc_fetch_sequencer against a rule-level reference model.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
    localparam int          MAXW   = 15;

    logic        clk = 1'b0;
    logic        rst, start, halt, redirect_valid, mem_ack, ir_ready;
    logic [31:0] redirect_pc, mem_data;
    logic        mem_req, ir_valid, timeout;
    logic [31:0] mem_addr, ir, ir_pc, pc;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    // reference model
    int          m_state, m_wait;
    logic [31:0] m_pc, m_ir, m_ir_pc, m_pend_pc;
    logic        m_ir_valid, m_timeout, m_hl, m_pend;

    // memory responder
    int          req_cyc = 0;
    int          cur_delay = 1;
    bit          ack_off = 0;
    bit          rand_mode = 0;

    always #5 clk = ~clk;

    pc_fetch_sequencer #(
        .WIDTH(32), .STEP(4), .RESET_PC(RST_PC), .MAX_WAIT(MAXW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc), .ir_ready(ir_ready),
        .pc(pc), .state(state), .timeout(timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    // States: 0 idle, 1 fetching, 2 holding a word for decode, 3 stopped.
    task automatic model_step();
        int          ns;
        logic [31:0] npc;
        if (rst) begin
            m_state = 0; m_pc = RST_PC; m_ir = 0; m_ir_pc = 0; m_ir_valid = 0;
            m_timeout = 0; m_hl = 0; m_pend = 0; m_pend_pc = 0; m_wait = 0;
            return;
        end
        ns  = m_state;
        npc = m_pc;
        case (m_state)
            0: begin
                if (redirect_valid) npc = redirect_pc;
                if (halt || m_hl) ns = 3;
                else if (start) begin ns = 1; m_wait = 0; end
            end
            1: begin
                if (mem_ack) begin
                    if (m_pend || redirect_valid) begin
                        npc = redirect_valid ? redirect_pc : m_pend_pc;
                        m_pend = 0;
                    end else begin
                        m_ir = mem_data; m_ir_pc = m_pc; npc = m_pc + 32'd4;
                        m_ir_valid = 1; ns = 2;
                    end
                    m_wait = 0;
                end else begin
                    if (redirect_valid) begin m_pend = 1; m_pend_pc = redirect_pc; end
                    m_wait++;
                    if (m_wait == MAXW) begin m_timeout = 1; ns = 3; end
                end
            end
            2: begin
                if (redirect_valid) npc = redirect_pc;
                if (ir_ready) begin
                    m_ir_valid = 0;
                    ns = (halt || m_hl) ? 3 : 1;
                    m_wait = 0;
                end
            end
            default: ;
        endcase
        if (halt && m_state != 3) m_hl = 1;
        m_state = ns;
        m_pc    = npc;
    endtask

    task automatic respond();
        mem_data = $urandom;
        if (m_state != 1 || ack_off) begin
            mem_ack = 0;
            req_cyc = 0;
        end else begin
            if (req_cyc == 0 && rand_mode)
                cur_delay = ($urandom_range(0, 19) == 0) ? 20 : int'($urandom_range(0, 3));
            mem_ack = (req_cyc >= cur_delay);
            req_cyc = mem_ack ? 0 : req_cyc + 1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("state",    32'(state),    32'(m_state));
        chk("pc",       pc,            m_pc);
        chk("mem_req",  32'(mem_req),  32'(m_state == 1));
        chk("mem_addr", mem_addr,      m_pc);
        chk("ir_valid", 32'(ir_valid), 32'(m_ir_valid));
        chk("ir",       ir,            m_ir);
        chk("ir_pc",    ir_pc,         m_ir_pc);
        chk("timeout",  32'(timeout),  32'(m_timeout));
        respond();
    endtask

    task automatic wait_ack();
        for (int i = 0; i < 40 && !mem_ack; i++) tick();
        chk("ack_wait", 32'(mem_ack), 32'd1);
    endtask

    initial begin
        logic [31:0] exp_addr [5];
        exp_addr = '{32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8, 32'hC};
        rst = 1; start = 0; halt = 0; redirect_valid = 0; redirect_pc = 0;
        mem_ack = 0; mem_data = 0; ir_ready = 0;

        // reset state
        tick();
        chk("rst_pc", pc, RST_PC);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_irv", 32'(ir_valid), 32'd0);
        chk("rst_tmo", 32'(timeout), 32'd0);
        tick();
        rst = 0;

        // sequential fetch with wrap past the top of the address space
        cur_delay = 1; ir_ready = 1;
        start = 1; tick(); start = 0;
        chk("first_req", 32'(mem_req), 32'd1);
        for (int k = 0; k < 5; k++) begin
            wait_ack();
            chk("seq_addr", mem_addr, exp_addr[k]);
            tick();
            chk("seq_irpc", ir_pc, exp_addr[k]);
            chk("seq_irv", 32'(ir_valid), 32'd1);
            chk("seq_pc", pc, exp_addr[k] + 32'd4);
        end
        chk("pc_after_seq", pc, 32'h10);

        // decode stall holds the instruction register
        tick();
        ir_ready = 0;
        wait_ack();
        mem_data = 32'hDEAD_BEEF;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_ir", ir, 32'hDEAD_BEEF);
            chk("stall_irpc", ir_pc, 32'h10);
            chk("stall_irv", 32'(ir_valid), 32'd1);
            chk("stall_req", 32'(mem_req), 32'd0);
        end
        ir_ready = 1;
        tick();
        chk("release_req", 32'(mem_req), 32'd1);
        chk("release_addr", mem_addr, 32'h14);

        // redirect while a fetch is outstanding
        cur_delay = 2;
        redirect_valid = 1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 0;
        chk("redir_hold_addr", mem_addr, 32'h14);
        wait_ack();
        chk("redir_ack_addr", mem_addr, 32'h14);
        tick();
        chk("redir_state", 32'(state), 32'd1);
        chk("redir_irv", 32'(ir_valid), 32'd0);
        chk("redir_addr", mem_addr, 32'h100);
        wait_ack();
        tick();
        chk("redir_irpc", ir_pc, 32'h100);
        chk("redir_pc", pc, 32'h104);

        // no ack ever: timeout after MAX_WAIT cycles of request
        ack_off = 1;
        tick();
        chk("tmo_req", 32'(mem_req), 32'd1);
        chk("tmo_addr", mem_addr, 32'h104);
        for (int k = 0; k < MAXW - 1; k++) tick();
        chk("tmo_not_yet", 32'(timeout), 32'd0);
        chk("tmo_still_fetch", 32'(state), 32'd1);
        tick();
        chk("tmo_flag", 32'(timeout), 32'd1);
        chk("tmo_halt", 32'(state), 32'd3);
        chk("tmo_req_drop", 32'(mem_req), 32'd0);
        start = 1; redirect_valid = 1; redirect_pc = 32'h40;
        for (int k = 0; k < 3; k++) tick();
        chk("halt_ign_state", 32'(state), 32'd3);
        chk("halt_ign_pc", pc, 32'h104);
        start = 0; redirect_valid = 0;
        rst = 1; tick(); rst = 0;
        chk("rerst_pc", pc, RST_PC);
        chk("rerst_tmo", 32'(timeout), 32'd0);
        chk("rerst_state", 32'(state), 32'd0);
        ack_off = 0;

        // halt during fetch completes the word before stopping
        cur_delay = 3; ir_ready = 0;
        start = 1; tick(); start = 0;
        halt = 1; tick(); halt = 0;
        wait_ack();
        tick();
        chk("hf_state", 32'(state), 32'd2);
        chk("hf_irv", 32'(ir_valid), 32'd1);
        chk("hf_irpc", ir_pc, RST_PC);
        ir_ready = 1;
        tick();
        chk("hf_halt", 32'(state), 32'd3);
        chk("hf_irv_drop", 32'(ir_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hf_no_req", 32'(mem_req), 32'd0);
        end

        // randomized episodes against the model
        rand_mode = 1;
        for (int ep = 0; ep < 30; ep++) begin
            rst = 1; tick(); rst = 0;
            for (int c = 0; c < 80; c++) begin
                rst            = ($urandom_range(0, 99) == 0);
                start          = ($urandom_range(0, 3) == 0);
                halt           = ($urandom_range(0, 59) == 0);
                redirect_valid = ($urandom_range(0, 7) == 0);
                redirect_pc    = $urandom;
                ir_ready       = ($urandom_range(0, 1) == 0);
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
